// File: rtl/osd_stm_trace_capture.sv
// osd_stm_trace_capture
// Watches a CPU trace port for marker instructions, pairs each marker id with
// a shadowed writeback register value, and buffers the {id, value} events in a
// first-word-fall-through FIFO drained over a valid/ready stream.
// Optional feature macro: STM_OVERFLOW_EN. When defined, a nonzero drop count
// is reported in-band as an id-0 record and then cleared; otherwise drops are
// only visible on the saturating 'dropped' output.
module osd_stm_trace_capture #(
    parameter int          XLEN       = 32,
    parameter int          VALWIDTH   = 32,
    parameter logic [15:0] MARKER     = 16'h1500,
    parameter int          SRC_REG    = 3,
    parameter int          DEPTH      = 4,
    parameter int          DROP_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         trace_valid,
    input  logic [XLEN-1:0]              trace_insn,
    input  logic                         trace_wben,
    input  logic [4:0]                   trace_wbreg,
    input  logic [XLEN-1:0]              trace_wbdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_id,
    output logic [VALWIDTH-1:0]          out_value,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [DROP_WIDTH-1:0]        dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_WIDTH'(1);
    endfunction

    // Truncate or zero-extend trace data to the emitted value width.
    function automatic logic [VALWIDTH-1:0] fit_val(input logic [XLEN-1:0] d);
        return VALWIDTH'(d);
    endfunction

    logic [XLEN-1:0]       shadow;
    logic [15:0]           mem_id  [DEPTH];
    logic [VALWIDTH-1:0]   mem_val [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [DROP_WIDTH-1:0] drop_cnt;
    logic [DROP_WIDTH-1:0] drop_nxt;

    // Stage p0: combinational event detection on the incoming trace record
    logic                wb_hit_p0;
    logic                evt_vld_p0;
    logic [15:0]         evt_id_p0;
    logic [VALWIDTH-1:0] evt_val_p0;
    logic                pop;
    logic                full;
    logic                slot;
    logic                push;
    logic [15:0]         push_id;
    logic [VALWIDTH-1:0] push_val;

    assign wb_hit_p0  = trace_wben && (trace_wbreg == 5'(SRC_REG));
    assign evt_vld_p0 = enable && trace_valid &&
                        (trace_insn[31:16] == MARKER) && (trace_insn[15:0] != 16'h0000);
    assign evt_id_p0  = trace_insn[15:0];
    // Same-cycle writeback bypasses the shadow so the event sees the newest value
    assign evt_val_p0 = fit_val(wb_hit_p0 ? trace_wbdata : shadow);

    assign out_valid  = (level != '0);
    assign pop        = out_valid && out_ready;
    assign full       = (level == LW'(DEPTH));
    assign slot       = !full || pop;

    // Select what (if anything) enters the FIFO and the next drop count.
    always_comb begin
        push     = 1'b0;
        push_id  = evt_id_p0;
        push_val = evt_val_p0;
        drop_nxt = drop_cnt;
`ifdef STM_OVERFLOW_EN
        if ((drop_cnt != '0) && slot) begin
            // Overflow record wins the slot; a colliding event is itself a drop
            push     = 1'b1;
            push_id  = 16'h0000;
            push_val = VALWIDTH'(drop_cnt);
            drop_nxt = evt_vld_p0 ? DROP_WIDTH'(1) : '0;
        end else if (evt_vld_p0) begin
            if (slot) push = 1'b1;
            else      drop_nxt = sat_inc(drop_cnt);
        end
`else
        if (evt_vld_p0) begin
            if (slot) push = 1'b1;
            else      drop_nxt = sat_inc(drop_cnt);
        end
`endif
    end

    // Shadow copy of the source register, tracked regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         shadow <= '0;
        else if (wb_hit_p0) shadow <= trace_wbdata;
    end

    // Stage p1: FIFO storage (data only, validity is carried by level)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]  <= push_id;
            mem_val[wr_ptr] <= push_val;
        end
    end

    // FIFO pointers, occupancy and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign out_id     = out_valid ? mem_id[rd_ptr]  : 16'h0000;
    assign out_value  = out_valid ? mem_val[rd_ptr] : '0;
    assign fifo_level = level;
    assign dropped    = drop_cnt;

endmodule

// File: doc/osd_stm_trace_capture.md
# osd_stm_trace_capture

Parametrised software-trace capture stage for the OSD System Trace Module path. It watches a CPU execution trace port for marker instructions (upper half equal to a configurable opcode, nonzero lower half) and pairs each marker with the value of a shadowed writeback register. Each captured {id, value} event is buffered in a DEPTH-entry FIFO and presented on a valid/ready stream to the STM packetiser. Unlike the fixed single-register wrapper, it has a configurable marker, source register, widths and buffer depth, supports backpressure, and reports dropped events.

## Interface
Parameters:
- XLEN, 32: width of trace instruction and writeback data.
- VALWIDTH, 32: width of emitted value; shadow register is truncated or zero-extended to it.
- MARKER, 16'h1500: required value of insn[31:16].
- SRC_REG, 3: writeback register index shadowed as the event value.
- DEPTH, 4: FIFO entries; a power of two, at least 2.
- DROP_WIDTH, 16: width of the saturating drop counter; at most VALWIDTH.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- enable  in  1  capture enable.
- trace_valid  in  1  trace record valid this cycle.
- trace_insn  in  XLEN  retired instruction.
- trace_wben  in  1  writeback enable.
- trace_wbreg  in  5  writeback register index.
- trace_wbdata  in  XLEN  writeback data.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_id  out  16  event id.
- out_value  out  VALWIDTH  event value.
- fifo_level  out  $clog2(DEPTH)+1  occupied entries.
- dropped  out  DROP_WIDTH  events lost since last report or reset.

## Operation
- Shadow: when trace_wben && trace_wbreg==SRC_REG, the shadow register loads trace_wbdata. The shadow is updated regardless of enable.
- Event: enable && trace_valid && insn[31:16]==MARKER && insn[15:0]!=0. The event id is insn[15:0].
- Value bypass: if a qualifying writeback occurs in the same cycle as an event, the event captures that cycle's trace_wbdata. Otherwise it captures the shadow.
- FIFO: first-word-fall-through.
  - out_valid = !empty.
  - A pop occurs when out_valid && out_ready.
  - out_id and out_value are forced to 0 while out_valid=0.
- Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Drop: an event arriving while the FIFO is full with no pop is discarded. dropped increments and saturates at 2^DROP_WIDTH-1.
- Simultaneous push and pop leave fifo_level unchanged. Pointers wrap modulo DEPTH.
- Deasserting enable stops new captures only. Buffered entries still drain.
- Id 0 is never produced by a normal event. It is reserved for overflow records (see Configuration).

## Timing
- Reset values: FIFO empty, out_valid=0, out_id=0, out_value=0, fifo_level=0, dropped=0, shadow=0.
- Reset acts immediately and discards buffered and in-flight events.
- Latency into an empty FIFO: event in cycle N gives out_valid=1 with that entry in cycle N+1.
- The head entry holds stable while out_valid && !out_ready.
- fifo_level and dropped are registered and reflect pushes, pops and drops of the previous cycle.
- The block sustains one event per cycle when out_ready is held high.

## Configuration
- STM_OVERFLOW_EN defined: in-band overflow reporting is compiled in.
  - Whenever dropped!=0 and a push slot is available, an overflow record is pushed with id=16'h0000 and value=dropped zero-extended.
  - dropped then clears.
  - The record takes priority over an event in the same cycle. That event is counted as a drop, so dropped becomes 1 instead of 0.
- STM_OVERFLOW_EN undefined: drops are silent in-band. dropped counts monotonically to saturation and clears only on reset.

## Test plan
- Shadow and bypass: write r3=0xDEADBEEF, then marker insn 0x15000007 → out id 0x0007, value 0xDEADBEEF. Marker 0x15000008 in the same cycle as r3 write 0x12345678 → value 0x12345678.
- Filtering: insn 0x15000000, 0x14000005, and 0x15000009 with enable=0 → no push, fifo_level stays 0.
- Backpressure and full: out_ready=0, DEPTH=4, six events ids 1..6 → fifo_level=4, dropped=2. Release out_ready → ids 1,2,3,4 in order.
- Full with simultaneous pop: FIFO full, out_ready=1 and a new event in the same cycle → event accepted, dropped unchanged, level stays 4.
- Overflow, STM_OVERFLOW_EN only: after the scenario above, drain one entry → overflow record id 0, value 2 is enqueued after id 4, and dropped returns to 0.
- Asynchronous reset mid-stream: assert rst_n=0 between clock edges with 3 entries buffered → out_valid=0 and fifo_level=0 immediately. The first event after release appears with 1-cycle latency.
